// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory access controller: turns load/store intent into a req/ack bus
// transaction, holds the pipeline until completion and flags misaligned or timed-out accesses.
module data_mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] Data_in,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        align_err,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] cnt_reg;
    logic       access;
    logic       aligned;
    logic       req_last;

    assign access   = mem_r | mem_w;
    assign aligned  = (addr[1:0] == 2'b00);
    assign req_last = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // An ack on the same cycle as the limit still counts as a normal completion.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (access && aligned)       state_next = ST_REQ;
            ST_REQ:  if (bus_ack || req_last)     state_next = ST_DONE;
            ST_DONE:                              state_next = ST_IDLE;
            default:                              state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_stall = 1'b0;
        case (state_reg)
            ST_IDLE: mem_stall = access & aligned;
            ST_REQ:  mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Data_in     <= 32'd0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'd0;
            bus_wdata   <= 32'd0;
            align_err   <= 1'b0;
            timeout_err <= 1'b0;
            cnt_reg     <= 8'd0;
        end else begin
            align_err   <= 1'b0;
            timeout_err <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_we    <= mem_w;
                            bus_wdata <= wdata;
                            bus_req   <= 1'b1;
                            cnt_reg   <= 8'd0;
                        end else begin
                            align_err <= 1'b1;
                            Data_in   <= 32'd0;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            Data_in <= bus_rdata;
                        end
                    end else if (req_last) begin
                        bus_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        Data_in     <= 32'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
